// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - opcode, state and ALU encodings shared by the control unit
package cu_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC_RD = 3'd2,
        ST_EXEC_WR = 3'd3,
        ST_HALT    = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    function automatic logic [1:0] alu_for(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_wait_timer.sv
// rtl/control_wait_timer.sv - saturating memory-wait counter with timeout flag
module control_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic wait_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The flag is qualified by wait_i so a ready on the limit cycle completes normally.
    assign timeout_o = (MEM_TIMEOUT != 0) && wait_i && (cnt_q == LIMIT);

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer for the 8-bit accumulator CPU
module control_unit
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IR_IN,
    input  logic       ZERO,
    input  logic       MEM_READY,
    output logic       HIR,
    output logic       INC_PC,
    output logic       HPC,
    output logic       ADDR_SEL,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       HACC,
    output logic [1:0] ALU_OP,
    output logic       HALTED,
    output logic       FAULT,
    output logic [2:0] STATE_OUT
);

    state_e state_q, state_d;
    logic   wait_en;
    logic   clear;
    logic   timeout;
    logic   unused_operand;

    assign unused_operand = &{1'b0, IR_IN[4:0]};

    // Kept outside the FSM block so the timer sees no loop through state_d.
    assign wait_en = !MEM_READY && ((state_q == ST_FETCH) ||
                                    (state_q == ST_EXEC_RD) ||
                                    (state_q == ST_EXEC_WR));
    assign clear   = (state_d != state_q);

    control_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk_i    (CLK),
        .resetn_i (RESET),
        .wait_i   (wait_en),
        .clear_i  (clear),
        .timeout_o(timeout)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        HIR       = 1'b0;
        INC_PC    = 1'b0;
        HPC       = 1'b0;
        ADDR_SEL  = 1'b0;
        MEM_RD    = 1'b0;
        MEM_WR    = 1'b0;
        HACC      = 1'b0;
        ALU_OP    = ALU_PASS;
        HALTED    = 1'b0;
        FAULT     = 1'b0;
        STATE_OUT = state_q;

        case (state_q)
            ST_FETCH: begin
                MEM_RD = 1'b1;
                if (MEM_READY) begin
                    HIR     = 1'b1;
                    INC_PC  = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                case (IR_IN[7:5])
                    OP_NOP:                 state_d = ST_FETCH;
                    OP_LDA, OP_ADD, OP_SUB: state_d = ST_EXEC_RD;
                    OP_STA:                 state_d = ST_EXEC_WR;
                    OP_JMP: begin
                        HPC     = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_JZ: begin
                        HPC     = ZERO;
                        state_d = ST_FETCH;
                    end
                    default:                state_d = ST_HALT;
                endcase
            end
            ST_EXEC_RD: begin
                ADDR_SEL = 1'b1;
                MEM_RD   = 1'b1;
                ALU_OP   = alu_for(IR_IN[7:5]);
                if (MEM_READY) begin
                    HACC    = 1'b1;
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC_WR: begin
                ADDR_SEL = 1'b1;
                MEM_WR   = 1'b1;
                if (MEM_READY) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                end
            end
            ST_HALT:  HALTED  = 1'b1;
            ST_FAULT: FAULT   = 1'b1;
            default:  state_d = ST_FAULT;
        endcase

        // Reset squashes every output, including the debug state, in the same cycle.
        if (!RESET) begin
            HIR       = 1'b0;
            INC_PC    = 1'b0;
            HPC       = 1'b0;
            ADDR_SEL  = 1'b0;
            MEM_RD    = 1'b0;
            MEM_WR    = 1'b0;
            HACC      = 1'b0;
            ALU_OP    = ALU_PASS;
            HALTED    = 1'b0;
            FAULT     = 1'b0;
            STATE_OUT = 3'd0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] IR_IN = 8'h00;
    logic       ZERO = 1'b0;
    logic       MEM_READY = 1'b1;
    logic       HIR, INC_PC, HPC, ADDR_SEL, MEM_RD, MEM_WR, HACC, HALTED, FAULT;
    logic [1:0] ALU_OP;
    logic [2:0] STATE_OUT;

    always #5 CLK = ~CLK;

    control_unit #(
        .MEM_TIMEOUT(4),
        .CNT_W      (3)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IR_IN    (IR_IN),
        .ZERO     (ZERO),
        .MEM_READY(MEM_READY),
        .HIR      (HIR),
        .INC_PC   (INC_PC),
        .HPC      (HPC),
        .ADDR_SEL (ADDR_SEL),
        .MEM_RD   (MEM_RD),
        .MEM_WR   (MEM_WR),
        .HACC     (HACC),
        .ALU_OP   (ALU_OP),
        .HALTED   (HALTED),
        .FAULT    (FAULT),
        .STATE_OUT(STATE_OUT)
    );

    logic [13:0] obs;
    assign obs = {HIR, INC_PC, HPC, ADDR_SEL, MEM_RD, MEM_WR, HACC,
                  ALU_OP, HALTED, FAULT, STATE_OUT};

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ev(input bit hir, input bit inc, input bit hpc,
                                       input bit asel, input bit rd, input bit wr,
                                       input bit hacc, input bit [1:0] alu,
                                       input bit halted, input bit flt, input bit [2:0] st);
        return {hir, inc, hpc, asel, rd, wr, hacc, alu, halted, flt, st};
    endfunction

    function automatic logic [13:0] v_fetch(input bit rdy);
        return ev(rdy, rdy, 0, 0, 1, 0, 0, 2'b00, 0, 0, 3'd0);
    endfunction

    function automatic logic [13:0] v_dec(input bit hpc);
        return ev(0, 0, hpc, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1);
    endfunction

    function automatic logic [13:0] v_rd(input bit [1:0] alu, input bit hacc);
        return ev(0, 0, 0, 1, 1, 0, hacc, alu, 0, 0, 3'd2);
    endfunction

    function automatic logic [13:0] v_wr();
        return ev(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 3'd3);
    endfunction

    function automatic logic [13:0] v_halt();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 3'd4);
    endfunction

    function automatic logic [13:0] v_fault();
        return ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'd5);
    endfunction

    // Drive one cycle of stimulus just after the edge and queue what it must produce.
    task automatic cyc(input bit rst, input logic [7:0] ir, input bit z, input bit rdy,
                       input logic [13:0] e, input string tag);
        @(posedge CLK);
        #1;
        RESET     = rst;
        IR_IN     = ir;
        ZERO      = z;
        MEM_READY = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge CLK) begin
        logic [13:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, obs, e);
        end
    end

    initial begin
        cyc(0, 8'h00, 0, 1, 14'd0, "reset0");
        cyc(0, 8'h00, 0, 1, 14'd0, "reset1");

        cyc(1, 8'h00, 0, 1, v_fetch(1), "nop_fetch");
        cyc(1, 8'h00, 0, 1, v_dec(0), "nop_decode");

        cyc(1, 8'h23, 0, 1, v_fetch(1), "lda_fetch");
        cyc(1, 8'h23, 0, 1, v_dec(0), "lda_decode");
        cyc(1, 8'h23, 0, 1, v_rd(2'b00, 1), "lda_exec");
        cyc(1, 8'h64, 0, 1, v_fetch(1), "add_fetch");
        cyc(1, 8'h64, 0, 1, v_dec(0), "add_decode");
        cyc(1, 8'h64, 0, 1, v_rd(2'b01, 1), "add_exec");
        cyc(1, 8'h85, 0, 1, v_fetch(1), "sub_fetch");
        cyc(1, 8'h85, 0, 1, v_dec(0), "sub_decode");
        cyc(1, 8'h85, 0, 1, v_rd(2'b10, 1), "sub_exec");

        cyc(1, 8'h23, 0, 1, v_fetch(1), "ldaw_fetch");
        cyc(1, 8'h23, 0, 1, v_dec(0), "ldaw_decode");
        cyc(1, 8'h23, 0, 0, v_rd(2'b00, 0), "ldaw_wait");
        cyc(1, 8'h23, 0, 1, v_rd(2'b00, 1), "ldaw_done");

        cyc(1, 8'hC7, 0, 1, v_fetch(1), "jz0_fetch");
        cyc(1, 8'hC7, 0, 1, v_dec(0), "jz0_decode");
        cyc(1, 8'hC7, 1, 1, v_fetch(1), "jz1_fetch");
        cyc(1, 8'hC7, 1, 1, v_dec(1), "jz1_decode");
        cyc(1, 8'hA1, 0, 1, v_fetch(1), "jmp0_fetch");
        cyc(1, 8'hA1, 0, 1, v_dec(1), "jmp0_decode");
        cyc(1, 8'hA1, 1, 1, v_fetch(1), "jmp1_fetch");
        cyc(1, 8'hA1, 1, 1, v_dec(1), "jmp1_decode");

        cyc(1, 8'h42, 0, 1, v_fetch(1), "sta_fetch");
        cyc(1, 8'h42, 0, 1, v_dec(0), "sta_decode");
        for (int i = 0; i < 3; i++) cyc(1, 8'h42, 0, 0, v_wr(), "sta_wait");
        cyc(1, 8'h42, 0, 1, v_wr(), "sta_done");

        for (int i = 0; i < 5; i++) cyc(1, 8'h00, 0, 0, v_fetch(0), "to_wait");
        for (int i = 0; i < 3; i++) cyc(1, 8'h00, 0, 0, v_fault(), "to_fault");
        for (int i = 0; i < 2; i++) cyc(1, 8'h00, 0, 1, v_fault(), "to_sticky");
        cyc(0, 8'h00, 0, 1, 14'd0, "to_reset");

        for (int i = 0; i < 4; i++) cyc(1, 8'h00, 0, 0, v_fetch(0), "race_wait");
        cyc(1, 8'h00, 0, 1, v_fetch(1), "race_ready");
        cyc(1, 8'h00, 0, 1, v_dec(0), "race_decode");

        cyc(1, 8'hFF, 0, 1, v_fetch(1), "hlt_fetch");
        cyc(1, 8'hFF, 0, 1, v_dec(0), "hlt_decode");
        for (int i = 0; i < 20; i++) cyc(1, 8'hFF, i[1], i[0], v_halt(), "halted");
        cyc(0, 8'hFF, 0, 1, 14'd0, "hlt_reset");

        cyc(1, 8'h23, 0, 1, v_fetch(1), "abort_fetch");
        cyc(1, 8'h23, 0, 1, v_dec(0), "abort_decode");
        cyc(1, 8'h23, 0, 0, v_rd(2'b00, 0), "abort_exec");
        cyc(0, 8'h23, 0, 1, 14'd0, "abort_reset");
        cyc(1, 8'h23, 0, 1, v_fetch(1), "abort_refetch");

        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU; sits directly downstream of the instruction register.
- Consumes the IR output and produces the IR load strobe HIR, plus PC, memory, accumulator and ALU control strobes.
- Waits on a memory-ready handshake, with an optional timeout that sends it to a sticky fault state.

Parameters:
- MEM_TIMEOUT, 15: max consecutive wait cycles with MEM_READY low before FAULT; 0 disables the timeout.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on rising CLK.
- IR_IN  in  8  instruction from IR; opcode = IR_IN[7:5], operand = IR_IN[4:0].
- ZERO  in  1  accumulator-zero flag from datapath.
- MEM_READY  in  1  memory completes the current read/write this cycle.
- HIR  out  1  IR load enable.
- INC_PC  out  1  PC increment.
- HPC  out  1  PC load from operand.
- ADDR_SEL  out  1  0 = PC drives address, 1 = IR operand drives address.
- MEM_RD  out  1  memory read request.
- MEM_WR  out  1  memory write request.
- HACC  out  1  accumulator load.
- ALU_OP  out  2  00 pass, 01 add, 10 sub, 11 reserved.
- HALTED  out  1  core halted.
- FAULT  out  1  memory timeout occurred (sticky).
- STATE_OUT  out  3  current state encoding (debug).

Behaviour:
- Opcode map: 000 NOP, 001 LDA, 010 STA, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 HLT.
- States: FETCH=0, DECODE=1, EXEC_RD=2, EXEC_WR=3, HALT=4, FAULT=5. Encodings 6-7 are illegal and go to FAULT.
- State and wait counter are registered. Strobes are combinational from state, IR_IN, ZERO and MEM_READY.
- Reset:
  - RESET=0 at an edge sets state to FETCH and the counter to 0.
  - While RESET=0, every output is forced to 0 combinationally, STATE_OUT included.
- FETCH:
  - ADDR_SEL=0, MEM_RD=1.
  - MEM_READY=1: HIR=1 and INC_PC=1 in that same cycle, so IR captures at the edge; next state DECODE.
- DECODE (IR_IN valid; 1 cycle; no memory strobes):
  - NOP goes to FETCH.
  - LDA, ADD, SUB go to EXEC_RD.
  - STA goes to EXEC_WR.
  - JMP: HPC=1, goes to FETCH.
  - JZ: HPC=ZERO, goes to FETCH.
  - HLT goes to HALT.
- EXEC_RD:
  - ADDR_SEL=1, MEM_RD=1.
  - ALU_OP = 00 (LDA), 01 (ADD) or 10 (SUB), held for the whole state.
  - MEM_READY=1: HACC=1, next state FETCH.
- EXEC_WR:
  - ADDR_SEL=1, MEM_WR=1.
  - MEM_READY=1: next state FETCH.
- HALT: HALTED=1, all strobes 0; leaves only on reset.
- FAULT: FAULT=1, all strobes 0; leaves only on reset.
- Wait counter:
  - Increments each FETCH, EXEC_RD or EXEC_WR cycle with MEM_READY=0.
  - Clears on every state change.
  - MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with MEM_READY=0: next state FAULT.
  - MEM_READY=1 in that same cycle wins: normal completion, no fault.
  - Counter saturates and never wraps.
- Latency with zero-wait memory: NOP, JMP, JZ, STA-less sequences = 2 cycles per instruction (FETCH+DECODE); LDA, ADD, SUB, STA = 3 cycles.
- Invariants: MEM_RD and MEM_WR are never both 1. HIR is only ever 1 in FETCH.
- Reset mid-instruction aborts it; no strobe is asserted in the reset cycle.

Decomposition:
- Package cu_pkg holds:
  - opcode constants OP_NOP..OP_HLT;
  - state encodings ST_FETCH..ST_FAULT;
  - ALU_OP codes ALU_PASS, ALU_ADD, ALU_SUB.
- One sub-module: control_wait_timer.
  - Inputs: CLK, RESET, wait enable, clear.
  - Output: a timeout flag.
  - Parameterised by MEM_TIMEOUT and CNT_W.

Test Plan:
- Reset low 2 cycles, then high with MEM_READY=1 and IR_IN=0x00: the first cycle after reset shows HIR=1, INC_PC=1, MEM_RD=1, STATE_OUT=0; the next cycle shows STATE_OUT=1 with all strobes 0.
- IR_IN=0x23 (LDA 3), MEM_READY=1: DECODE, then EXEC_RD with ADDR_SEL=1, MEM_RD=1, ALU_OP=00, HACC=1, then FETCH. Repeat with 0x64 (ADD): ALU_OP=01. Repeat with 0x85 (SUB): ALU_OP=10.
- IR_IN=0xC7 (JZ 7): with ZERO=0, HPC=0 in DECODE; with ZERO=1, HPC=1. JMP 0xA1 gives HPC=1 regardless of ZERO.
- STA 0x42 with MEM_READY held low 3 cycles then high: MEM_WR=1 held 4 cycles, no HACC, then FETCH; no FAULT with MEM_TIMEOUT=15.
- MEM_READY stuck low in FETCH with MEM_TIMEOUT=4: FAULT=1 after 5 cycles in FETCH and stays 1. RESET=0 clears it. Also check MEM_READY rising on the timeout cycle gives no fault.
- IR_IN=0xFF (HLT): HALTED=1 from the cycle after DECODE and stays for 20 cycles with all strobes 0. Assert RESET=0 mid-EXEC_RD: all outputs 0 that cycle, then FETCH.
